// File: rtl/mul_unit.sv
// mul_unit: iterative radix-2 shift-add integer multiplier (MUL/MULH/MULHSU/MULHU).
// An accepted operation completes with a one-cycle valid_o pulse exactly
// 33 rising edges after acceptance; flush_i aborts, rst (sync, high) clears all.
module mul_unit #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       sub_op,
  input  logic [31:0]      op1,
  input  logic [31:0]      op2,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [31:0]      result_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int unsigned DW = 32;
  localparam int unsigned PW = 64;
  localparam int unsigned CW = 5;
  localparam logic [CW-1:0] LAST_STEP = CW'(31);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0]       r_op;
  logic [TAG_W-1:0] r_tag;
  logic             r_neg;
  logic [PW-1:0]    r_mcand;
  logic [DW-1:0]    r_mplier;
  logic [PW-1:0]    r_prod;
  logic [CW-1:0]    r_count;

  logic             r_ready;
  logic             r_valid;
  logic [DW-1:0]    r_result;
  logic [TAG_W-1:0] r_tag_out;

  logic             w_accept;
  logic             w_sign1;
  logic             w_sign2;
  logic [DW-1:0]    w_mag1;
  logic [DW-1:0]    w_mag2;
  logic [PW-1:0]    w_prod_fix;
  logic             w_unused;

  // Only sub_op[1:0] selects the operation.
  assign w_unused = sub_op[2];

  // Operand signedness and magnitudes (0x80000000 negates to itself = 2^31).
  always_comb begin
    w_sign1 = op1[DW-1] & (sub_op[1:0] != 2'b11);
    w_sign2 = op2[DW-1] & ~sub_op[1];
    w_mag1  = w_sign1 ? (DW'(0) - op1) : op1;
    w_mag2  = w_sign2 ? (DW'(0) - op2) : op2;
  end

  // Signed-corrected full product, applied in the DONE cycle.
  always_comb begin
    w_prod_fix = r_neg ? (PW'(0) - r_prod) : r_prod;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; flush always returns to IDLE and blocks acceptance.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    if (flush_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            w_accept    = 1'b1;
            w_state_nxt = S_CALC;
          end
        end
        S_CALC: begin
          if (r_count == LAST_STEP) w_state_nxt = S_DONE;
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath: latch operation on accept, one multiplier bit per CALC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= 2'b00;
      r_tag    <= '0;
      r_neg    <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_count  <= '0;
    end else if (w_accept) begin
      r_op     <= sub_op[1:0];
      r_tag    <= tag_i;
      r_neg    <= w_sign1 ^ w_sign2;
      r_mcand  <= {DW'(0), w_mag1};
      r_mplier <= w_mag2;
      r_prod   <= '0;
      r_count  <= '0;
    end else if (r_state == S_CALC) begin
      if (r_mplier[0]) r_prod <= r_prod + r_mcand;
      r_mcand  <= {r_mcand[PW-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[DW-1:1]};
      r_count  <= r_count + CW'(1);
    end
  end

  // Registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready   <= 1'b1;
      r_valid   <= 1'b0;
      r_result  <= '0;
      r_tag_out <= '0;
    end else if (flush_i) begin
      r_ready <= 1'b1;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_ready <= 1'b0;
      r_valid <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_ready   <= 1'b1;
      r_valid   <= 1'b1;
      r_result  <= (r_op == 2'b00) ? w_prod_fix[DW-1:0] : w_prod_fix[PW-1:DW];
      r_tag_out <= r_tag;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign ready_o  = r_ready;
  assign valid_o  = r_valid;
  assign result_o = r_result;
  assign tag_o    = r_tag_out;

endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: directed vector table, corner sequences and random ops
// against an arithmetic reference model of mul_unit.
module tb_mul_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  sub_op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [3:0]  tag_i;
  logic        flush_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] result_o;
  logic [3:0]  tag_o;

  int vectors = 0;
  int miscompares = 0;

  mul_unit #(.TAG_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .sub_op   (sub_op),
    .op1      (op1),
    .op2      (op2),
    .tag_i    (tag_i),
    .flush_i  (flush_i),
    .ready_o  (ready_o),
    .valid_o  (valid_o),
    .result_o (result_o),
    .tag_o    (tag_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;

  // Reference: sign/zero-extend to 64 bits, multiply modulo 2^64, pick half.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] xa, xb, p;
    xa = (op[1:0] != 2'b11 && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
    xb = (!op[1] && b[31])           ? {32'hFFFF_FFFF, b} : {32'h0, b};
    p  = xa * xb;
    return (op[1:0] == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; the next edge is the acceptance edge E0.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag);
    sub_op  = op;
    op1     = a;
    op2     = b;
    tag_i   = tag;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  // Count edges until valid_o is seen, bounded at 40.
  task automatic wait_valid(output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 lat++;
      if (valid_o) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] tag, input logic [31:0] exp);
    int lat;
    bit seen;
    issue(op, a, b, tag);
    chk({name, "_busy"}, 32'(ready_o), 32'd0);
    wait_valid(lat, seen);
    chk({name, "_seen"}, 32'(seen), 32'd1);
    chk({name, "_lat"}, 32'(lat), 32'd33);
    chk({name, "_res"}, result_o, exp);
    chk({name, "_tag"}, 32'(tag_o), 32'(tag));
    chk({name, "_rdy"}, 32'(ready_o), 32'd1);
  endtask

  vec_t tbl[8];

  initial begin
    int lat;
    bit seen;
    logic [31:0] prev;

    tbl[0] = '{3'b000, 32'd7,         32'hFFFF_FFFD, 4'd3,  32'hFFFF_FFEB};
    tbl[1] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 4'd4,  32'h4000_0000};
    tbl[2] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5,  32'hFFFF_FFFE};
    tbl[3] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6,  32'hFFFF_FFFF};
    tbl[4] = '{3'b000, 32'd0,         32'h8000_0000, 4'd7,  32'h0000_0000};
    tbl[5] = '{3'b100, 32'd3,         32'd4,         4'd8,  32'd12};
    tbl[6] = '{3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd9,  32'd0};
    tbl[7] = '{3'b111, 32'h8000_0000, 32'd2,         4'd10, 32'd1};

    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
    sub_op = 3'b0; op1 = '0; op2 = '0; tag_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_tag", 32'(tag_o), 32'd0);

    // Directed table, issued back-to-back in each valid cycle.
    foreach (tbl[i]) begin
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].tag, tbl[i].exp);
    end
    @(posedge clk);
    #1 chk("valid_pulse_clear", 32'(valid_o), 32'd0);
    chk("result_hold", result_o, 32'd1);

    // Flush in the 10th CALC cycle, then a clean op.
    issue(3'b000, 32'd123, 32'd456, 4'd2);
    repeat (9) @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    chk("flush_ready", 32'(ready_o), 32'd1);
    chk("flush_valid", 32'(valid_o), 32'd0);
    wait_valid(lat, seen);
    chk("flush_no_valid", 32'(seen), 32'd0);
    run_op("after_flush", 3'b000, 32'd5, 32'd6, 4'd11, 32'd30);

    // Flush in the DONE cycle suppresses completion.
    issue(3'b000, 32'd9, 32'd9, 4'd12);
    repeat (32) @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    chk("dflush_valid", 32'(valid_o), 32'd0);
    chk("dflush_ready", 32'(ready_o), 32'd1);
    chk("dflush_hold", result_o, 32'd30);

    // Flush together with start in IDLE: start must not be accepted.
    sub_op = 3'b000; op1 = 32'd2; op2 = 32'd2; tag_i = 4'd1;
    start_i = 1'b1; flush_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0; flush_i = 1'b0;
    chk("flush_wins_ready", 32'(ready_o), 32'd1);
    wait_valid(lat, seen);
    chk("flush_wins_no_valid", 32'(seen), 32'd0);

    // start_i held through CALC with other operands, then taken in valid cycle.
    sub_op = 3'b000; op1 = 32'd11; op2 = 32'd13; tag_i = 4'd13;
    start_i = 1'b1;
    @(posedge clk);
    #1 op1 = 32'd100; op2 = 32'd200; tag_i = 4'd14; sub_op = 3'b011;
    wait_valid(lat, seen);
    chk("held_lat", 32'(lat), 32'd33);
    chk("held_res", result_o, 32'd143);
    chk("held_tag", 32'(tag_o), 32'd13);
    @(posedge clk);
    #1 start_i = 1'b0;
    chk("b2b_busy", 32'(ready_o), 32'd0);
    chk("b2b_valid_clr", 32'(valid_o), 32'd0);
    wait_valid(lat, seen);
    chk("b2b_lat", 32'(lat), 32'd33);
    chk("b2b_res", result_o, model(3'b011, 32'd100, 32'd200));
    chk("b2b_tag", 32'(tag_o), 32'd14);

    // Reset mid-CALC.
    @(posedge clk);
    #1 issue(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 4'd15);
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mrst_ready", 32'(ready_o), 32'd1);
    chk("mrst_valid", 32'(valid_o), 32'd0);
    chk("mrst_result", result_o, 32'd0);
    chk("mrst_tag", 32'(tag_o), 32'd0);
    wait_valid(lat, seen);
    chk("mrst_no_valid", 32'(seen), 32'd0);
    run_op("after_rst", 3'b000, 32'hFFFF_FFF0, 32'd3, 4'd6, 32'hFFFF_FFD0);

    // Randomised ops against the reference model.
    for (int n = 0; n < 24; n++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom();
      rb  = $urandom();
      if (n % 6 == 1) ra = 32'h8000_0000;
      if (n % 6 == 2) rb = 32'hFFFF_FFFF;
      if (n % 6 == 3) ra = 32'd0;
      prev = model(rop, ra, rb);
      run_op($sformatf("rnd%0d", n), rop, ra, rb, 4'(n), prev);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
